// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle CPU.
// master = control FSM, slave = datapath side.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             ir_we;
  logic             pc_we;
  logic             jump;
  logic             beq;
  logic             bne;
  logic             regorimm;
  logic             link;
  logic             reg_we;
  logic             regdst;
  logic             alusrc;
  logic [2:0]       aluop;
  logic             mem_re;
  logic             mem_we;
  logic             memtoreg;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output ir_we, pc_we, jump, beq, bne,
    output regorimm, link, reg_we, regdst,
    output alusrc, aluop, mem_re, mem_we,
    output memtoreg, illegal, instret
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  ir_we, pc_we, jump, beq, bne,
    input  regorimm, link, reg_we, regdst,
    input  alusrc, aluop, mem_re, mem_we,
    input  memtoreg, illegal, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle CPU.
// Sequences PC unit, regfile, ALU and memory; counts retirements.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_ADD, C_SUB, C_SLT, C_JR,
    C_LW, C_SW, C_ADDI, C_XORI,
    C_BEQ, C_BNE, C_J, C_JAL, C_ILL
  } cls_t;

  state_t           state;
  state_t           state_nx;
  cls_t             cls;
  cls_t             dec;
  logic [CNT_W-1:0] cnt;
  logic             retire;
  logic             is_r;
  logic [2:0]       alu_op;
  logic             alu_src;

  logic ir_we, pc_we, jump, beq, bne;
  logic regorimm, link, reg_we, regdst;
  logic alusrc, mem_re, mem_we;
  logic memtoreg, illegal;
  logic [2:0] aluop;

  assign is_r = (bus.opcode == 6'b000000);

  // Classify the instruction presented during DECODE.
  always_comb begin
    dec = C_ILL;
    unique case (1'b1)
      is_r && bus.funct == 6'b100000: dec = C_ADD;
      is_r && bus.funct == 6'b100010: dec = C_SUB;
      is_r && bus.funct == 6'b101010: dec = C_SLT;
      is_r && bus.funct == 6'b001000: dec = C_JR;
      bus.opcode == 6'b100011:        dec = C_LW;
      bus.opcode == 6'b101011:        dec = C_SW;
      bus.opcode == 6'b001000:        dec = C_ADDI;
      bus.opcode == 6'b001110:        dec = C_XORI;
      bus.opcode == 6'b000100:        dec = C_BEQ;
      bus.opcode == 6'b000101:        dec = C_BNE;
      bus.opcode == 6'b000010:        dec = C_J;
      bus.opcode == 6'b000011:        dec = C_JAL;
      default:                        dec = C_ILL;
    endcase
  end

  // ALU control implied by the latched class.
  always_comb begin
    alu_op  = 3'b000;
    alu_src = 1'b0;
    unique case (cls)
      C_SUB, C_BEQ, C_BNE: alu_op = 3'b001;
      C_SLT:               alu_op = 3'b010;
      C_XORI: begin
        alu_op  = 3'b011;
        alu_src = 1'b1;
      end
      C_ADDI, C_LW, C_SW:  alu_src = 1'b1;
      default: ;
    endcase
  end

  // State, latched class and retirement counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      cls   <= C_NONE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE) cls <= dec;
      if (retire) cnt <= cnt + 1'b1;
    end
  end

  // Next state and per-state control outputs.
  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    jump     = 1'b0;
    beq      = 1'b0;
    bne      = 1'b0;
    regorimm = 1'b0;
    link     = 1'b0;
    reg_we   = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    aluop    = 3'b000;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    memtoreg = 1'b0;
    illegal  = 1'b0;
    unique case (state)
      FETCH: begin
        ir_we    = 1'b1;
        state_nx = DECODE;
      end
      DECODE: begin
        unique case (dec)
          C_ILL: begin
            illegal  = 1'b1;
            pc_we    = 1'b1;
            state_nx = FETCH;
          end
          C_J, C_JAL, C_JR: begin
            pc_we    = 1'b1;
            jump     = 1'b1;
            regorimm = (dec == C_JR);
            link     = (dec == C_JAL);
            reg_we   = (dec == C_JAL);
            retire   = 1'b1;
            state_nx = FETCH;
          end
          default: state_nx = EXEC;
        endcase
      end
      EXEC: begin
        aluop  = alu_op;
        alusrc = alu_src;
        unique case (cls)
          C_BEQ, C_BNE: begin
            pc_we    = 1'b1;
            beq      = (cls == C_BEQ) && bus.zero;
            bne      = (cls == C_BNE) && !bus.zero;
            retire   = 1'b1;
            state_nx = FETCH;
          end
          C_LW, C_SW: state_nx = MEM;
          default:    state_nx = WB;
        endcase
      end
      MEM: begin
        aluop  = alu_op;
        alusrc = alu_src;
        mem_re = (cls == C_LW);
        mem_we = (cls == C_SW);
        if (bus.mem_ready) begin
          if (cls == C_LW) begin
            state_nx = WB;
          end else begin
            pc_we    = 1'b1;
            retire   = 1'b1;
            state_nx = FETCH;
          end
        end
      end
      WB: begin
        aluop    = alu_op;
        alusrc   = alu_src;
        reg_we   = 1'b1;
        pc_we    = 1'b1;
        regdst   = (cls == C_ADD) || (cls == C_SUB) || (cls == C_SLT);
        memtoreg = (cls == C_LW);
        retire   = 1'b1;
        state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  // Reset forces every output quiet, aborting any in-flight commit.
  assign bus.ir_we    = reset & ir_we;
  assign bus.pc_we    = reset & pc_we;
  assign bus.jump     = reset & jump;
  assign bus.beq      = reset & beq;
  assign bus.bne      = reset & bne;
  assign bus.regorimm = reset & regorimm;
  assign bus.link     = reset & link;
  assign bus.reg_we   = reset & reg_we;
  assign bus.regdst   = reset & regdst;
  assign bus.alusrc   = reset & alusrc;
  assign bus.aluop    = reset ? aluop : 3'b000;
  assign bus.mem_re   = reset & mem_re;
  assign bus.mem_we   = reset & mem_we;
  assign bus.memtoreg = reset & memtoreg;
  assign bus.illegal  = reset & illegal;
  assign bus.instret  = reset ? cnt : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control.
// Expected cycle sequences are built per instruction from its class.
module tb_multicycle_control;

  localparam int CW = 4;

  localparam int K_ADD  = 0;
  localparam int K_SUB  = 1;
  localparam int K_SLT  = 2;
  localparam int K_JR   = 3;
  localparam int K_LW   = 4;
  localparam int K_SW   = 5;
  localparam int K_ADDI = 6;
  localparam int K_XORI = 7;
  localparam int K_BEQ  = 8;
  localparam int K_BNE  = 9;
  localparam int K_J    = 10;
  localparam int K_JAL  = 11;
  localparam int K_ILL  = 12;

  localparam int B_IR  = 11;
  localparam int B_PC  = 10;
  localparam int B_JMP = 9;
  localparam int B_BEQ = 8;
  localparam int B_BNE = 7;
  localparam int B_ROI = 6;
  localparam int B_LNK = 5;
  localparam int B_RWE = 4;
  localparam int B_MRE = 3;
  localparam int B_MWE = 2;
  localparam int B_M2R = 1;
  localparam int B_ILL = 0;

  typedef struct packed {
    logic [11:0] ctl;
    logic        ca;
    logic [3:0]  alu;
    logic        cd;
    logic        dst;
    logic        z;
    logic        mr;
    logic        dec;
    logic        ret;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cnt_m = 0;

  multicycle_control_if #(.CNT_W(CW)) bus ();

  multicycle_control #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ctl_now();
    return {bus.ir_we, bus.pc_we, bus.jump, bus.beq,
            bus.bne, bus.regorimm, bus.link, bus.reg_we,
            bus.mem_re, bus.mem_we, bus.memtoreg, bus.illegal};
  endfunction

  function automatic logic [31:0] all_now();
    return 32'({ctl_now(), bus.regdst, bus.alusrc,
                bus.aluop, bus.instret});
  endfunction

  function automatic bit legal(input logic [5:0] op,
                               input logic [5:0] fn);
    if (op == 6'b000000)
      return fn inside {6'b100000, 6'b100010,
                        6'b101010, 6'b001000};
    return op inside {6'b100011, 6'b101011, 6'b001000,
                      6'b001110, 6'b000100, 6'b000101,
                      6'b000010, 6'b000011};
  endfunction

  task automatic enc(input int k,
                     output logic [5:0] op,
                     output logic [5:0] fn);
    fn = 6'($urandom);
    case (k)
      K_ADD:  begin op = 6'b000000; fn = 6'b100000; end
      K_SUB:  begin op = 6'b000000; fn = 6'b100010; end
      K_SLT:  begin op = 6'b000000; fn = 6'b101010; end
      K_JR:   begin op = 6'b000000; fn = 6'b001000; end
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_ADDI: op = 6'b001000;
      K_XORI: op = 6'b001110;
      K_BEQ:  op = 6'b000100;
      K_BNE:  op = 6'b000101;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      default: begin
        do begin
          op = 6'($urandom);
          fn = 6'($urandom);
        end while (legal(op, fn));
      end
    endcase
  endtask

  // {aluop, alusrc} each class requires
  function automatic logic [3:0] alu_of(input int k);
    case (k)
      K_SUB, K_BEQ, K_BNE:  return 4'b001_0;
      K_SLT:                return 4'b010_0;
      K_XORI:               return 4'b011_1;
      K_LW, K_SW, K_ADDI:   return 4'b000_1;
      default:              return 4'b000_0;
    endcase
  endfunction

  function automatic rec_t blank();
    rec_t r;
    r    = '0;
    r.z  = 1'($urandom);
    r.mr = 1'($urandom);
    return r;
  endfunction

  task automatic step(input logic rst,
                      input logic [5:0] op,
                      input logic [5:0] fn,
                      input logic z,
                      input logic mr);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = mr;
    @(negedge clk);
  endtask

  task automatic run_raw(input int k,
                         input logic [5:0] op,
                         input logic [5:0] fn,
                         input logic z,
                         input int n);
    rec_t q[$];
    rec_t r;
    bool_t_dummy: begin end
    r = blank();
    r.ctl[B_IR] = 1'b1;
    q.push_back(r);
    r = blank();
    r.dec = 1'b1;
    if (k == K_ILL) begin
      r.ctl[B_PC]  = 1'b1;
      r.ctl[B_ILL] = 1'b1;
    end else if (k == K_J || k == K_JAL || k == K_JR) begin
      r.ctl[B_PC]  = 1'b1;
      r.ctl[B_JMP] = 1'b1;
      r.ctl[B_ROI] = (k == K_JR);
      r.ctl[B_LNK] = (k == K_JAL);
      r.ctl[B_RWE] = (k == K_JAL);
      r.ret        = 1'b1;
    end
    q.push_back(r);
    if (!(k inside {K_ILL, K_J, K_JAL, K_JR})) begin
      r = blank();
      r.ca  = 1'b1;
      r.alu = alu_of(k);
      r.z   = z;
      if (k == K_BEQ || k == K_BNE) begin
        r.ctl[B_PC]  = 1'b1;
        r.ctl[B_BEQ] = (k == K_BEQ) && z;
        r.ctl[B_BNE] = (k == K_BNE) && !z;
        r.ret        = 1'b1;
        q.push_back(r);
      end else begin
        q.push_back(r);
        if (k == K_LW || k == K_SW) begin
          for (int i = 0; i <= n; i++) begin
            r = blank();
            r.mr = (i == n);
            r.ctl[B_MRE] = (k == K_LW);
            r.ctl[B_MWE] = (k == K_SW);
            if (i == n && k == K_SW) begin
              r.ctl[B_PC] = 1'b1;
              r.ret       = 1'b1;
            end
            q.push_back(r);
          end
        end
        if (k != K_SW) begin
          r = blank();
          r.ctl[B_RWE] = 1'b1;
          r.ctl[B_PC]  = 1'b1;
          r.ctl[B_M2R] = (k == K_LW);
          r.ca  = 1'b1;
          r.alu = alu_of(k);
          r.cd  = 1'b1;
          r.dst = (k inside {K_ADD, K_SUB, K_SLT});
          r.ret = 1'b1;
          q.push_back(r);
        end
      end
    end
    foreach (q[i]) begin
      r = q[i];
      if (r.dec)
        step(1'b1, op, fn, r.z, r.mr);
      else
        step(1'b1, 6'($urandom), 6'($urandom), r.z, r.mr);
      chk("ctl", 32'(ctl_now()), 32'(r.ctl));
      chk("instret", 32'(bus.instret), 32'(cnt_m));
      if (r.ca)
        chk("alu", 32'({bus.aluop, bus.alusrc}), 32'(r.alu));
      if (r.cd)
        chk("regdst", 32'(bus.regdst), 32'(r.dst));
      if (r.ret)
        cnt_m = (cnt_m + 1) % (1 << CW);
    end
  endtask

  task automatic run_k(input int k, input logic z, input int n);
    logic [5:0] op;
    logic [5:0] fn;
    enc(k, op, fn);
    run_raw(k, op, fn, z, n);
  endtask

  initial begin
    bus.opcode    = '0;
    bus.funct     = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    repeat (2) begin
      step(1'b0, 6'($urandom), 6'($urandom), 1'b1, 1'b1);
      chk("reset_out", all_now(), 32'd0);
    end
    cnt_m = 0;

    repeat (3) run_k(K_ADDI, 1'b0, 0);
    run_k(K_BEQ, 1'b1, 0);
    run_k(K_BEQ, 1'b0, 0);
    run_k(K_BNE, 1'b0, 0);
    run_k(K_BNE, 1'b1, 0);
    run_k(K_JAL, 1'b0, 0);
    run_k(K_JR, 1'b0, 0);
    run_k(K_LW, 1'b0, 3);
    run_k(K_SW, 1'b0, 2);
    run_raw(K_ILL, 6'b111111, 6'b000000, 1'b0, 0);
    run_k(K_ADD, 1'b0, 0);
    run_k(K_SUB, 1'b0, 0);
    run_k(K_SLT, 1'b0, 0);
    run_k(K_XORI, 1'b0, 0);
    run_k(K_J, 1'b0, 0);

    // reset aborts a lw stalled in MEM
    step(1'b1, 6'($urandom), 6'($urandom), 1'b0, 1'b0);
    chk("abort_fetch", 32'(ctl_now()), 32'h800);
    step(1'b1, 6'b100011, 6'b000000, 1'b0, 1'b0);
    step(1'b1, 6'($urandom), 6'($urandom), 1'b0, 1'b0);
    repeat (2) begin
      step(1'b1, 6'($urandom), 6'($urandom), 1'b0, 1'b0);
      chk("stall_mem_re", 32'(ctl_now()), 32'h008);
    end
    step(1'b0, 6'($urandom), 6'($urandom), 1'b0, 1'b1);
    chk("abort_out", all_now(), 32'd0);
    cnt_m = 0;
    run_k(K_ADDI, 1'b0, 0);

    for (int i = 0; i < 300; i++)
      run_k($urandom_range(0, 12), 1'($urandom),
            $urandom_range(0, 3));

    // 16 retirements wrap the 4-bit counter to zero
    step(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    chk("reset_out2", all_now(), 32'd0);
    cnt_m = 0;
    repeat (16) run_k(K_J, 1'b0, 0);
    run_k(K_ILL, 1'b0, 0);
    chk("wrap", 32'(cnt_m), 32'(bus.instret));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
